// File: rtl/if_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : if_fetch_queue                                                |
// | Brief    : PC generation, pipelined I-SRAM fetch with credit-limited     |
// |            outstanding requests, stale-response discard after redirect   |
// |            and an in-order decoupling queue toward decode.               |
// |            Optional macro IF_MISALIGN_EXC_EN: misaligned redirect target |
// |            yields one exception entry instead of fetching.               |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module if_fetch_queue #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [XLEN-1:0] new_pc,
  input  logic [XLEN:0]   br_bus,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst,
  output logic            if_exc,
  output logic            inst_sram_en,
  output logic [XLEN-1:0] inst_sram_addr,
  input  logic            inst_sram_rvalid,
  input  logic [31:0]     inst_sram_rdata
);

  localparam int                 c_ptr_w      = $clog2(QDEPTH);
  localparam int                 c_cnt_w      = c_ptr_w + 1;
  localparam logic [c_cnt_w:0]   c_credit_max = (c_cnt_w + 1)'(QDEPTH);
  localparam logic [31:0]        c_nop        = 32'h0000_0013;
  localparam logic [XLEN-1:0]    c_align_mask = XLEN'(3);
  localparam logic [XLEN-1:0]    c_pc_step    = XLEN'(4);
  localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  logic [XLEN-1:0]    r_fetch_pc;
  logic [c_cnt_w-1:0] r_outstanding;
  logic [c_cnt_w-1:0] r_drop_cnt;
  logic               r_halt;

  logic [XLEN-1:0]    r_q_pc   [QDEPTH];
  logic [31:0]        r_q_inst [QDEPTH];
`ifdef IF_MISALIGN_EXC_EN
  logic               r_q_exc  [QDEPTH];
`endif
  logic [c_ptr_w-1:0] r_q_head;
  logic [c_ptr_w-1:0] r_q_tail;
  logic [c_cnt_w-1:0] r_q_count;

  logic [XLEN-1:0]    r_pf_mem [QDEPTH];
  logic [c_ptr_w-1:0] r_pf_head;
  logic [c_ptr_w-1:0] r_pf_tail;

  logic               w_br_e;
  logic               w_redirect;
  logic [XLEN-1:0]    w_target_raw;
  logic [XLEN-1:0]    w_target;
  logic               w_misalign;
  logic [c_cnt_w:0]   w_credit_sum;
  logic               w_issue;
  logic               w_rsp;
  logic               w_accept;
  logic               w_deq;

  assign w_br_e       = br_bus[XLEN];
  assign w_redirect   = flush | w_br_e;
  assign w_target_raw = flush ? new_pc : br_bus[XLEN-1:0];

`ifdef IF_MISALIGN_EXC_EN
  assign w_target   = w_target_raw;
  assign w_misalign = w_redirect & ((w_target_raw & c_align_mask) != '0);
`else
  assign w_target   = w_target_raw & ~c_align_mask;
  assign w_misalign = 1'b0;
`endif

  // Credits cover queued entries plus every in-flight response, dropped ones included.
  assign w_credit_sum = {1'b0, r_q_count} + {1'b0, r_outstanding};
  assign w_issue      = rst_n & ~w_redirect & ~r_halt & (w_credit_sum < c_credit_max);
  assign w_rsp        = inst_sram_rvalid & (r_outstanding != '0);
  assign w_accept     = w_rsp & (r_drop_cnt == '0) & ~w_redirect;
  assign if_valid     = rst_n & (r_q_count != '0);
  assign w_deq        = if_valid & id_ready;

  assign inst_sram_en   = w_issue;
  assign inst_sram_addr = r_fetch_pc;
  assign if_pc          = r_q_pc[r_q_head];
  assign if_inst        = r_q_inst[r_q_head];
`ifdef IF_MISALIGN_EXC_EN
  assign if_exc         = r_q_exc[r_q_head];
`else
  assign if_exc         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_halt        <= 1'b0;
      r_q_head      <= '0;
      r_q_tail      <= '0;
      r_q_count     <= '0;
      r_pf_head     <= '0;
      r_pf_tail     <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_pc[i]   <= RESET_PC;
        r_q_inst[i] <= c_nop;
`ifdef IF_MISALIGN_EXC_EN
        r_q_exc[i]  <= 1'b0;
`endif
        r_pf_mem[i] <= RESET_PC;
      end
    end else begin
      r_outstanding <= r_outstanding + (w_issue ? c_cnt_one : '0) - (w_rsp ? c_cnt_one : '0);
      if (w_redirect) begin
        // Everything still in flight belongs to the old stream.
        r_drop_cnt <= r_outstanding - (w_rsp ? c_cnt_one : '0);
        r_fetch_pc <= w_target;
        r_halt     <= w_misalign;
        r_q_head   <= '0;
        r_pf_head  <= '0;
        r_pf_tail  <= '0;
        if (w_misalign) begin
          r_q_pc[0]   <= w_target;
          r_q_inst[0] <= c_nop;
`ifdef IF_MISALIGN_EXC_EN
          r_q_exc[0]  <= 1'b1;
`endif
          r_q_tail    <= c_ptr_one;
          r_q_count   <= c_cnt_one;
        end else begin
          r_q_tail    <= '0;
          r_q_count   <= '0;
        end
      end else begin
        if (w_rsp && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - c_cnt_one;
        end
        if (w_issue) begin
          r_fetch_pc           <= r_fetch_pc + c_pc_step;
          r_pf_mem[r_pf_tail]  <= r_fetch_pc;
          r_pf_tail            <= r_pf_tail + c_ptr_one;
        end
        if (w_accept) begin
          r_q_pc[r_q_tail]   <= r_pf_mem[r_pf_head];
          r_q_inst[r_q_tail] <= inst_sram_rdata;
`ifdef IF_MISALIGN_EXC_EN
          r_q_exc[r_q_tail]  <= 1'b0;
`endif
          r_q_tail           <= r_q_tail + c_ptr_one;
          r_pf_head          <= r_pf_head + c_ptr_one;
        end
        if (w_deq) begin
          r_q_head <= r_q_head + c_ptr_one;
        end
        r_q_count <= r_q_count + (w_accept ? c_cnt_one : '0) - (w_deq ? c_cnt_one : '0);
      end
    end
  end

endmodule
`default_nettype wire
